// File: rtl/zero_flag_pipe.sv
// Pipelined zero/negative detector for the ALU result bus: an OR-reduction tree of
// configurable fan-in, with optional per-level registers and architectural Z/N flags.
module zero_flag_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned FANIN = 4,
  parameter int unsigned PIPE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_setf,
  input  logic             clear,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             flag_z,
  output logic             flag_n,
  output logic             busy
);

  function automatic int unsigned calc_levels(input int unsigned w, input int unsigned f);
    int unsigned n;
    int unsigned l;
    n = w;
    l = 0;
    while (n > 1) begin
      n = (n + f - 1) / f;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int unsigned LEVELS = calc_levels(WIDTH, FANIN);
  localparam int unsigned STAGES = (PIPE != 0) ? LEVELS : 1;
  localparam int unsigned LAST   = STAGES - 1;

  // One tree level: bit g of the result ORs bits g*FANIN .. g*FANIN+FANIN-1.
  // Bits above the previous level's width are always 0, which pads a short last group.
  function automatic logic [WIDTH-1:0] or_level(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i / FANIN] = r[i / FANIN] | v[i];
    end
    return r;
  endfunction

  logic [LEVELS-1:0][WIDTH-1:0] src;
  logic                         final_or;

  assign src[0] = in_data;

  for (genvar j = 1; j < LEVELS; j++) begin : g_lvl
    logic [WIDTH-1:0] or_v;
    assign or_v = or_level(src[j-1]);
    if (PIPE != 0) begin : g_pipe
      logic [WIDTH-1:0] d_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) d_q <= '0;
        else          d_q <= or_v;
      end
      assign src[j] = d_q;
    end else begin : g_comb
      assign src[j] = or_v;
    end
  end

  // The last level is a single group, so a full reduction gives the same result.
  assign final_or = |src[LEVELS-1];

  logic [STAGES-1:0] v_q, v_d, s_q, s_d, n_q, n_d;
  logic              zero_q, zero_d;
  logic              fz_q, fn_q, busy_q;

  // Sideband shift: valid/setf/negative travel with the tree data; payload bits
  // are forced low in any empty stage so the outputs read 0 whenever out_valid is 0.
  always_comb begin
    v_d    = '0;
    s_d    = '0;
    n_d    = '0;
    zero_d = 1'b0;
    v_d[0] = in_valid & ~clear;
    s_d[0] = in_setf;
    n_d[0] = in_data[WIDTH-1];
    for (int unsigned i = 1; i < STAGES; i++) begin
      v_d[i] = v_q[i-1] & ~clear;
      s_d[i] = s_q[i-1];
      n_d[i] = n_q[i-1];
    end
    s_d    = s_d & v_d;
    n_d    = n_d & v_d;
    zero_d = v_d[LAST] & ~final_or;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q    <= '0;
      s_q    <= '0;
      n_q    <= '0;
      zero_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      v_q    <= v_d;
      s_q    <= s_d;
      n_q    <= n_d;
      zero_q <= zero_d;
      busy_q <= |v_d;
    end
  end

  // Architectural flags: clear takes priority over a retiring flag-setting result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fz_q <= 1'b0;
      fn_q <= 1'b0;
    end else if (clear) begin
      fz_q <= 1'b0;
      fn_q <= 1'b0;
    end else if (v_q[LAST] && s_q[LAST]) begin
      fz_q <= zero_q;
      fn_q <= n_q[LAST];
    end
  end

  assign out_valid = v_q[LAST];
  assign zero      = zero_q;
  assign negative  = n_q[LAST];
  assign flag_z    = fz_q;
  assign flag_n    = fn_q;
  assign busy      = busy_q;

endmodule
